// File: rtl/bp_fpga_host_io_arbiter.sv
// -----------------------------------------------------------------------------
// bp_fpga_host_io_arbiter
//
// Round-robin arbiter/sequencer sharing the single BedRock I/O command/response
// port of bp_fpga_host between num_req_p requesters. One command is accepted,
// forwarded to the host, and the host response is routed back to the requester
// that issued it. Exactly one transaction is outstanding at any time.
//
// Message layout (io_msg_width_lp bits, MSB first):
//   [msg_type:4][size:3][addr:paddr_width_p][data:data_width_p]
// The header is everything above the data field; data sits in the low bits.
//
// Optional feature macro: BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
//   Defined   -> response timeout after timeout_cycles_p cycles in e_wait, an
//                error response (command header, zero data) to the owner,
//                a sticky timeout_o, and stale host responses are drained.
//   Undefined -> e_wait waits forever, timeout_o is tied low.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_cmd_i/_v_i          per-requester command message and valid
//   req_cmd_ready_and_o     one-hot accept (ready&valid)
//   req_resp_o              response message, broadcast to all requesters
//   req_resp_v_o            one-hot response valid (owner only)
//   req_resp_yumi_i         per-requester response consume
//   io_cmd_o/_v_o           command to host, valid
//   io_cmd_ready_and_i      host ready
//   io_resp_i/_v_i          host response, valid
//   io_resp_yumi_o          consume to host
//   busy_o                  high whenever not idle
//   grant_id_o              id of current or most recent owner
//   timeout_o               sticky timeout flag
// -----------------------------------------------------------------------------
module bp_fpga_host_io_arbiter #(
  parameter int paddr_width_p    = 40,
  parameter int data_width_p     = 64,
  parameter int num_req_p        = 4,
  parameter int timeout_cycles_p = 65536,
  localparam int hdr_width_lp    = 4 + 3 + paddr_width_p,
  localparam int io_msg_width_lp = hdr_width_lp + data_width_p,
  localparam int id_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,

  input  logic [num_req_p*io_msg_width_lp-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]                 req_cmd_v_i,
  output logic [num_req_p-1:0]                 req_cmd_ready_and_o,

  output logic [io_msg_width_lp-1:0]           req_resp_o,
  output logic [num_req_p-1:0]                 req_resp_v_o,
  input  logic [num_req_p-1:0]                 req_resp_yumi_i,

  output logic [io_msg_width_lp-1:0]           io_cmd_o,
  output logic                                 io_cmd_v_o,
  input  logic                                 io_cmd_ready_and_i,

  input  logic [io_msg_width_lp-1:0]           io_resp_i,
  input  logic                                 io_resp_v_i,
  output logic                                 io_resp_yumi_o,

  output logic                                 busy_o,
  output logic [id_width_lp-1:0]               grant_id_o,
  output logic                                 timeout_o
);

  localparam logic [1:0] e_idle = 2'd0;
  localparam logic [1:0] e_send = 2'd1;
  localparam logic [1:0] e_wait = 2'd2;
`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
  localparam logic [1:0] e_err  = 2'd3;
`endif

  logic [1:0]                 state_r;
  logic [io_msg_width_lp-1:0] cmd_r;
  logic [id_width_lp-1:0]     owner_r;
  logic [id_width_lp-1:0]     ptr_r;

  // Per-requester view of the flattened command bus.
  logic [io_msg_width_lp-1:0] req_cmd_li [num_req_p];

  // Arbitration result for the current e_idle cycle.
  logic                       win_v_li;
  logic [id_width_lp-1:0]     win_id_li;

  // Response valid before it is steered onto the owner's bit.
  logic                       resp_v_li;
  logic                       owner_yumi_li;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_req
      assign req_cmd_li[gi] = req_cmd_i[gi*io_msg_width_lp +: io_msg_width_lp];

      // Accept is withheld while reset is asserted so a resetting arbiter
      // never takes a command it is about to forget.
      assign req_cmd_ready_and_o[gi] = (state_r == e_idle) & ~reset_i & win_v_li
                                       & (win_id_li == id_width_lp'(gi));

      assign req_resp_v_o[gi] = resp_v_li & (owner_r == id_width_lp'(gi));
    end
  endgenerate

  // Round-robin search: scan offsets from the highest down so the lowest
  // offset from ptr_r (the highest-priority requester) wins last.
  always_comb begin
    int                     idx;
    logic [id_width_lp-1:0] idx_id;
    win_v_li  = 1'b0;
    win_id_li = '0;
    idx       = 0;
    idx_id    = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = int'(ptr_r) + k;
      if (idx >= num_req_p) begin
        idx = idx - num_req_p;
      end
      idx_id = id_width_lp'(idx);
      if (req_cmd_v_i[idx_id]) begin
        win_v_li  = 1'b1;
        win_id_li = idx_id;
      end
    end
  end

  // Only the owner's consume counts; other requesters' yumi bits are ignored.
  assign owner_yumi_li = req_resp_yumi_i[owner_r];

  // Command side: the host sees the latched command only in e_send.
  assign io_cmd_v_o = (state_r == e_send);
  assign io_cmd_o   = io_cmd_v_o ? cmd_r : '0;

  assign busy_o     = (state_r != e_idle);
  assign grant_id_o = owner_r;

`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
  localparam int tcnt_width_lp = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;

  logic [tcnt_width_lp-1:0] tcnt_r;
  logic                     timeout_r;
  logic                     timeout_hit_li;

  // The counter advances on every e_wait cycle without a consume; the cycle
  // in which it steps onto timeout_cycles_p-1 is the one that enters e_err,
  // so the error response appears timeout_cycles_p cycles after the command
  // handshake.
  assign timeout_hit_li = (state_r == e_wait) & ~io_resp_yumi_o
                          & (tcnt_r == tcnt_width_lp'(timeout_cycles_p - 2));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tcnt_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      if ((state_r == e_send) && io_cmd_ready_and_i) begin
        tcnt_r <= '0;
      end else if ((state_r == e_wait) && !io_resp_yumi_o) begin
        tcnt_r <= tcnt_r + 1'b1;
      end
      if (timeout_hit_li) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_r;
`else
  assign timeout_o = 1'b0;
`endif

  // Response side.
  always_comb begin
    resp_v_li      = 1'b0;
    req_resp_o     = '0;
    io_resp_yumi_o = 1'b0;
    case (state_r)
      e_wait: begin
        resp_v_li      = io_resp_v_i;
        req_resp_o     = io_resp_i;
        io_resp_yumi_o = io_resp_v_i & owner_yumi_li;
      end
`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
      e_err: begin
        // Synthesized error reply: original header, zero data. Anything the
        // host sends now belongs to the abandoned transaction and is drained.
        resp_v_li      = 1'b1;
        req_resp_o     = {cmd_r[io_msg_width_lp-1 -: hdr_width_lp], {data_width_p{1'b0}}};
        io_resp_yumi_o = io_resp_v_i & ~reset_i;
      end
      default: begin
        // Late response from a timed-out transaction: consume and drop it.
        io_resp_yumi_o = io_resp_v_i & ~reset_i;
      end
`else
      default: begin
        io_resp_yumi_o = 1'b0;
      end
`endif
    endcase
  end

  // Sequencer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      cmd_r   <= '0;
      owner_r <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (win_v_li) begin
            cmd_r   <= req_cmd_li[win_id_li];
            owner_r <= win_id_li;
            ptr_r   <= (win_id_li == id_width_lp'(num_req_p - 1)) ? '0 : win_id_li + 1'b1;
            state_r <= e_send;
          end
        end
        e_send: begin
          if (io_cmd_ready_and_i) begin
            state_r <= e_wait;
          end
        end
        e_wait: begin
          if (io_resp_yumi_o) begin
            state_r <= e_idle;
          end
`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
          else if (timeout_hit_li) begin
            state_r <= e_err;
          end
`endif
        end
`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
        e_err: begin
          if (owner_yumi_li) begin
            state_r <= e_idle;
          end
        end
`endif
        default: begin
          // Unreachable encoding: recover to idle.
          state_r <= e_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_fpga_host_io_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for bp_fpga_host_io_arbiter (4 requesters).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_bp_fpga_host_io_arbiter;

  localparam int N  = 4;
  localparam int PA = 40;
  localparam int DW = 64;
  localparam int TO = 16;
  localparam int HW = 7 + PA;
  localparam int W  = HW + DW;

  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] req_cmd_i;
  logic [N-1:0]   req_cmd_v_i;
  logic [N-1:0]   req_cmd_ready_and_o;
  logic [W-1:0]   req_resp_o;
  logic [N-1:0]   req_resp_v_o;
  logic [N-1:0]   req_resp_yumi_i;
  logic [W-1:0]   io_cmd_o;
  logic           io_cmd_v_o;
  logic           io_cmd_ready_and_i;
  logic [W-1:0]   io_resp_i;
  logic           io_resp_v_i;
  logic           io_resp_yumi_o;
  logic           busy_o;
  logic [1:0]     grant_id_o;
  logic           timeout_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_fpga_host_io_arbiter #(
    .paddr_width_p(PA), .data_width_p(DW), .num_req_p(N), .timeout_cycles_p(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_ready_and_o(req_cmd_ready_and_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .busy_o(busy_o), .grant_id_o(grant_id_o), .timeout_o(timeout_o)
  );

  // One line per completed requester-side response.
  always @(posedge clk) begin
    if (!reset_i && (|(req_resp_v_o & req_resp_yumi_i))) begin
      $display("txn: owner=%0d resp_v=%b resp=%h timeout=%0b",
               grant_id_o, req_resp_v_o, req_resp_o, timeout_o);
    end
  end

  function automatic logic [W-1:0] mk(input logic [3:0] t, input logic [PA-1:0] a,
                                      input logic [DW-1:0] d);
    return {t, 3'd3, a, d};
  endfunction

  task automatic clr_inputs();
    req_cmd_i          = '0;
    req_cmd_v_i        = '0;
    req_resp_yumi_i    = '0;
    io_cmd_ready_and_i = 1'b0;
    io_resp_i          = '0;
    io_resp_v_i        = 1'b0;
  endtask

  task automatic test_reset();
    clr_inputs();
    reset_i = 1'b1;
    req_cmd_i[0 +: W] = mk(UC_WR, 40'h1, 64'h1);
    req_cmd_v_i = 4'b1111;
    io_resp_v_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (req_cmd_ready_and_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_cmd_ready_and_o); end
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_io_cmd_v: got %b want 0", io_cmd_v_o); end
    checks++; if (io_cmd_o !== '0) begin errors++; $display("FAIL reset_io_cmd: got %h want 0", io_cmd_o); end
    checks++; if (req_resp_v_o !== 4'b0000) begin errors++; $display("FAIL reset_resp_v: got %b want 0000", req_resp_v_o); end
    checks++; if (req_resp_o !== '0) begin errors++; $display("FAIL reset_resp: got %h want 0", req_resp_o); end
    checks++; if (io_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi: got %b want 0", io_resp_yumi_o); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    clr_inputs();
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [W-1:0] c;
    logic [W-1:0] r;
    c = mk(UC_WR, 40'h00_0010_1000, 64'h41);
    r = mk(UC_WR, 40'h00_0010_1000, 64'h0);
    req_cmd_i[0 +: W] = c;
    req_cmd_v_i = 4'b0001;
    io_cmd_ready_and_i = 1'b1;
    #1;
    checks++; if (req_cmd_ready_and_o !== 4'b0001) begin errors++; $display("FAIL sw_accept: got %b want 0001", req_cmd_ready_and_o); end
    @(negedge clk);
    req_cmd_v_i = 4'b0000;
    #1;
    checks++; if (io_cmd_v_o !== 1'b1) begin errors++; $display("FAIL sw_cmd_v: got %b want 1", io_cmd_v_o); end
    checks++; if (io_cmd_o[7:0] !== 8'h41) begin errors++; $display("FAIL sw_cmd_data: got %h want 41", io_cmd_o[7:0]); end
    checks++; if (io_cmd_o !== c) begin errors++; $display("FAIL sw_cmd_msg: got %h want %h", io_cmd_o, c); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b want 1", busy_o); end
    @(negedge clk);
    io_cmd_ready_and_i = 1'b0;
    #1;
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL sw_cmd_v_drop: got %b want 0", io_cmd_v_o); end
    checks++; if (req_resp_v_o !== 4'b0000) begin errors++; $display("FAIL sw_no_resp: got %b want 0000", req_resp_v_o); end
    @(negedge clk);
    io_resp_i = r;
    io_resp_v_i = 1'b1;
    req_resp_yumi_i = 4'b1110;  // non-owners only: must not complete
    #1;
    checks++; if (req_resp_v_o !== 4'b0001) begin errors++; $display("FAIL sw_resp_v: got %b want 0001", req_resp_v_o); end
    checks++; if (req_resp_o !== r) begin errors++; $display("FAIL sw_resp: got %h want %h", req_resp_o, r); end
    checks++; if (io_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL sw_nonowner_yumi: got %b want 0", io_resp_yumi_o); end
    @(negedge clk);
    req_resp_yumi_i = 4'b0001;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sw_still_busy: got %b want 1", busy_o); end
    checks++; if (io_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL sw_yumi: got %b want 1", io_resp_yumi_o); end
    @(negedge clk);
    clr_inputs();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sw_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    c1 = mk(UC_WR, 40'h100, 64'h11);
    c2 = mk(UC_WR, 40'h200, 64'h22);
    clr_inputs();
    reset_i = 1'b1;
    req_cmd_i[1*W +: W] = c1;
    req_cmd_i[2*W +: W] = c2;
    req_cmd_v_i = 4'b0110;
    io_cmd_ready_and_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++; if (req_cmd_ready_and_o !== 4'b0010) begin errors++; $display("FAIL sim_first_accept: got %b want 0010", req_cmd_ready_and_o); end
    @(negedge clk);
    req_cmd_v_i = 4'b0100;
    #1;
    checks++; if (grant_id_o !== 2'd1) begin errors++; $display("FAIL sim_grant1: got %0d want 1", grant_id_o); end
    checks++; if (io_cmd_o !== c1) begin errors++; $display("FAIL sim_cmd1: got %h want %h", io_cmd_o, c1); end
    checks++; if (req_cmd_ready_and_o !== 4'b0000) begin errors++; $display("FAIL sim_no_accept_send: got %b want 0000", req_cmd_ready_and_o); end
    @(negedge clk);
    io_resp_v_i = 1'b1;
    io_resp_i = c1;
    req_resp_yumi_i = 4'b0010;
    #1;
    checks++; if (req_resp_v_o !== 4'b0010) begin errors++; $display("FAIL sim_resp1: got %b want 0010", req_resp_v_o); end
    @(negedge clk);
    io_resp_v_i = 1'b0;
    req_resp_yumi_i = 4'b0000;
    #1;
    checks++; if (req_cmd_ready_and_o !== 4'b0100) begin errors++; $display("FAIL sim_second_accept: got %b want 0100", req_cmd_ready_and_o); end
    @(negedge clk);
    req_cmd_v_i = 4'b0000;
    #1;
    checks++; if (grant_id_o !== 2'd2) begin errors++; $display("FAIL sim_grant2: got %0d want 2", grant_id_o); end
    checks++; if (io_cmd_o !== c2) begin errors++; $display("FAIL sim_cmd2: got %h want %h", io_cmd_o, c2); end
    @(negedge clk);
    io_resp_v_i = 1'b1;
    io_resp_i = c2;
    req_resp_yumi_i = 4'b0100;
    #1;
    checks++; if (req_resp_v_o !== 4'b0100) begin errors++; $display("FAIL sim_resp2: got %b want 0100", req_resp_v_o); end
    @(negedge clk);
    clr_inputs();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_fairness();
    logic [W-1:0] c [N];
    logic [N-1:0] exp_oh;
    int           e;
    clr_inputs();
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i] = mk(UC_RD, PA'(40'h1000 + i * 40'h100), DW'(i + 1));
      req_cmd_i[i*W +: W] = c[i];
    end
    req_cmd_v_i = 4'b1111;
    io_cmd_ready_and_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = k % N;
      exp_oh = 4'(1 << e);
      #1;
      checks++; if (req_cmd_ready_and_o !== exp_oh) begin errors++; $display("FAIL fair_accept[%0d]: got %b want %b", k, req_cmd_ready_and_o, exp_oh); end
      @(negedge clk);
      #1;
      checks++; if (grant_id_o !== 2'(e)) begin errors++; $display("FAIL fair_grant[%0d]: got %0d want %0d", k, grant_id_o, e); end
      checks++; if (io_cmd_o !== c[e]) begin errors++; $display("FAIL fair_cmd[%0d]: got %h want %h", k, io_cmd_o, c[e]); end
      @(negedge clk);
      io_resp_v_i = 1'b1;
      io_resp_i = c[e];
      req_resp_yumi_i = exp_oh;
      #1;
      checks++; if (req_resp_v_o !== exp_oh) begin errors++; $display("FAIL fair_resp[%0d]: got %b want %b", k, req_resp_v_o, exp_oh); end
      @(negedge clk);
      io_resp_v_i = 1'b0;
      req_resp_yumi_i = 4'b0000;
      if (k == 7) begin
        req_cmd_v_i = 4'b0000;
      end
    end
    clr_inputs();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] c;
    c = mk(UC_WR, 40'h2000, 64'hdead);
    clr_inputs();
    req_cmd_i[0 +: W] = c;
    req_cmd_i[1*W +: W] = mk(UC_WR, 40'h2100, 64'hbeef);
    req_cmd_v_i = 4'b0011;
    #1;
    checks++; if (req_cmd_ready_and_o !== 4'b0001) begin errors++; $display("FAIL bp_accept: got %b want 0001", req_cmd_ready_and_o); end
    @(negedge clk);
    req_cmd_v_i = 4'b0010;  // requester 1 keeps asking throughout
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (io_cmd_v_o !== 1'b1) begin errors++; $display("FAIL bp_cmd_v[%0d]: got %b want 1", i, io_cmd_v_o); end
      checks++; if (io_cmd_o !== c) begin errors++; $display("FAIL bp_cmd_stable[%0d]: got %h want %h", i, io_cmd_o, c); end
      checks++; if (req_cmd_ready_and_o !== 4'b0000) begin errors++; $display("FAIL bp_no_accept[%0d]: got %b want 0000", i, req_cmd_ready_and_o); end
      @(negedge clk);
    end
    io_cmd_ready_and_i = 1'b1;
    #1;
    checks++; if (io_cmd_v_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", io_cmd_v_o); end
    @(negedge clk);
    io_cmd_ready_and_i = 1'b0;
    io_resp_v_i = 1'b1;
    io_resp_i = c;
    req_resp_yumi_i = 4'b0001;
    #1;
    checks++; if (req_resp_v_o !== 4'b0001) begin errors++; $display("FAIL bp_resp: got %b want 0001", req_resp_v_o); end
    @(negedge clk);
    io_resp_v_i = 1'b0;
    req_resp_yumi_i = 4'b0000;
    #1;
    checks++; if (req_cmd_ready_and_o !== 4'b0010) begin errors++; $display("FAIL bp_next_accept: got %b want 0010", req_cmd_ready_and_o); end
    @(negedge clk);
    req_cmd_v_i = 4'b0000;
    io_cmd_ready_and_i = 1'b1;
    #1;
    checks++; if (grant_id_o !== 2'd1) begin errors++; $display("FAIL bp_grant1: got %0d want 1", grant_id_o); end
    @(negedge clk);
    io_resp_v_i = 1'b1;
    req_resp_yumi_i = 4'b0010;
    @(negedge clk);
    clr_inputs();
  endtask

`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [W-1:0] c;
    logic [W-1:0] exp_err;
    c = mk(UC_RD, 40'h3000, 64'h0123_4567_89ab_cdef);
    exp_err = c;
    exp_err[DW-1:0] = '0;
    clr_inputs();
    req_cmd_i[0 +: W] = c;
    req_cmd_v_i = 4'b0001;
    io_cmd_ready_and_i = 1'b1;
    @(negedge clk);          // accepted, now in send
    req_cmd_v_i = 4'b0000;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      io_cmd_ready_and_i = 1'b0;
      #1;
      checks++; if (req_resp_v_o !== 4'b0000) begin errors++; $display("FAIL to_early_resp[%0d]: got %b want 0000", k, req_resp_v_o); end
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_early_flag[%0d]: got %b want 0", k, timeout_o); end
    end
    @(negedge clk);
    io_resp_v_i = 1'b1;
    io_resp_i = mk(UC_RD, 40'h3000, 64'hffff);
    #1;
    checks++; if (req_resp_v_o !== 4'b0001) begin errors++; $display("FAIL to_resp_v: got %b want 0001", req_resp_v_o); end
    checks++; if (req_resp_o !== exp_err) begin errors++; $display("FAIL to_resp: got %h want %h", req_resp_o, exp_err); end
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout_o); end
    checks++; if (io_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL to_stale_drop: got %b want 1", io_resp_yumi_o); end
    @(negedge clk);
    req_resp_yumi_i = 4'b0001;
    @(negedge clk);
    req_resp_yumi_i = 4'b0000;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", busy_o); end
    checks++; if (req_resp_v_o !== 4'b0000) begin errors++; $display("FAIL to_not_routed: got %b want 0000", req_resp_v_o); end
    checks++; if (io_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL to_idle_drop: got %b want 1", io_resp_yumi_o); end
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
    @(negedge clk);
    clr_inputs();
  endtask
`else
  task automatic test_no_timeout();
    logic [W-1:0] c;
    c = mk(UC_RD, 40'h3000, 64'h77);
    clr_inputs();
    req_cmd_i[0 +: W] = c;
    req_cmd_v_i = 4'b0001;
    io_cmd_ready_and_i = 1'b1;
    @(negedge clk);
    req_cmd_v_i = 4'b0000;
    @(negedge clk);
    io_cmd_ready_and_i = 1'b0;
    for (int k = 0; k < 3 * TO; k++) begin
      @(negedge clk);
    end
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL nto_busy: got %b want 1", busy_o); end
    checks++; if (req_resp_v_o !== 4'b0000) begin errors++; $display("FAIL nto_resp_v: got %b want 0000", req_resp_v_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL nto_flag: got %b want 0", timeout_o); end
    io_resp_v_i = 1'b1;
    io_resp_i = c;
    req_resp_yumi_i = 4'b0001;
    @(negedge clk);
    clr_inputs();
    io_resp_v_i = 1'b1;      // response while idle must not be consumed
    #1;
    checks++; if (io_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL nto_idle_yumi: got %b want 0", io_resp_yumi_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL nto_idle: got %b want 0", busy_o); end
    io_resp_v_i = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_wait();
    logic [W-1:0] c;
    c = mk(UC_WR, 40'h4000, 64'h55);
    clr_inputs();
    req_cmd_i[0 +: W] = c;
    req_cmd_i[1*W +: W] = mk(UC_WR, 40'h4100, 64'h66);
    req_cmd_v_i = 4'b0001;
    io_cmd_ready_and_i = 1'b1;
    @(negedge clk);
    req_cmd_v_i = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmw_in_wait: got %b want 1", busy_o); end
    reset_i = 1'b1;
    req_cmd_v_i = 4'b0011;
    io_resp_v_i = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmw_busy: got %b want 0", busy_o); end
    checks++; if (req_cmd_ready_and_o !== 4'b0000) begin errors++; $display("FAIL rmw_ready: got %b want 0000", req_cmd_ready_and_o); end
    checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL rmw_cmd_v: got %b want 0", io_cmd_v_o); end
    checks++; if (req_resp_v_o !== 4'b0000) begin errors++; $display("FAIL rmw_resp_v: got %b want 0000", req_resp_v_o); end
    checks++; if (io_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL rmw_yumi: got %b want 0", io_resp_yumi_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rmw_timeout: got %b want 0", timeout_o); end
    reset_i = 1'b0;
    io_resp_v_i = 1'b0;
    #1;
    // ptr_r back at 0: requester 0 beats requester 1 even though 0 was last owner.
    checks++; if (req_cmd_ready_and_o !== 4'b0001) begin errors++; $display("FAIL rmw_accept0: got %b want 0001", req_cmd_ready_and_o); end
    @(negedge clk);
    req_cmd_v_i = 4'b0000;
    #1;
    checks++; if (io_cmd_o !== c) begin errors++; $display("FAIL rmw_cmd: got %h want %h", io_cmd_o, c); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL rmw_grant: got %0d want 0", grant_id_o); end
    @(negedge clk);
    io_resp_v_i = 1'b1;
    io_resp_i = c;
    req_resp_yumi_i = 4'b0001;
    #1;
    checks++; if (req_resp_v_o !== 4'b0001) begin errors++; $display("FAIL rmw_resp: got %b want 0001", req_resp_v_o); end
    @(negedge clk);
    clr_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    clr_inputs();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_fairness();
    test_backpressure();
`ifdef BP_FPGA_HOST_IO_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
